// File: rtl/crossyroad_game_seq.sv
// crossyroad_game_seq
//   Game sequencer for the crossy-road VGA game. It synchronizes and debounces
//   the move button and keeps one buffered move request. It runs the
//   IDLE/PLAY/SCROLL/DEAD state machine and produces the scroll offset, the
//   lane-advance pulse and the score that the renderer consumes. Game state
//   changes only on frame_tick, so the picture never changes in the middle of
//   a frame.
//
// Ports
//   clk            in   system/pixel clock
//   rst_man        in   synchronous active-high reset
//   move_btn       in   raw asynchronous button, active high
//   frame_tick     in   1-cycle pulse at the start of vertical blank
//   collision      in   player pixel overlapped a car pixel this cycle
//   state          out  0=IDLE 1=PLAY 2=SCROLL 3=DEAD
//   scroll_offset  out  vertical scroll in pixels, 0..LANE_H-SCROLL_STEP
//   lane_advance   out  1-cycle pulse when the world advances one lane
//   score          out  lanes crossed this game, saturates at 255
//   game_over      out  high while in DEAD
module crossyroad_game_seq #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LANE_H          = 32,
    parameter int SCROLL_STEP     = 4,
    parameter int DEAD_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       rst_man,
    input  logic       move_btn,
    input  logic       frame_tick,
    input  logic       collision,
    output logic [1:0] state,
    output logic [4:0] scroll_offset,
    output logic       lane_advance,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]      STEP_EXT = 6'(SCROLL_STEP);
    localparam logic [5:0]      LANE_EXT = 6'(LANE_H);
    localparam logic [7:0]      DEAD_MAX = 8'(DEAD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_SCROLL = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;
    logic            move_pending_q, move_pending_d;
    logic            coll_latch_q, coll_latch_d;
    logic [7:0]      dead_cnt_q, dead_cnt_d;
    logic [4:0]      scroll_q, scroll_d;
    logic            lane_adv_q, lane_adv_d;
    logic [7:0]      score_q, score_d;
    logic            game_over_q, game_over_d;

    logic            press_rise;
    logic            consume;
    logic            col;
    logic [5:0]      scroll_sum;

    always_comb begin
        sync1_d        = move_btn;
        sync2_d        = sync1_q;
        db_cnt_d       = db_cnt_q;
        db_level_d     = db_level_q;
        press_rise     = 1'b0;
        consume        = 1'b0;
        state_d        = state_q;
        scroll_d       = scroll_q;
        lane_adv_d     = 1'b0;
        score_d        = score_q;
        dead_cnt_d     = dead_cnt_q;
        coll_latch_d   = coll_latch_q | collision;
        col            = coll_latch_q | collision;
        scroll_sum     = {1'b0, scroll_q} + STEP_EXT;

        // Debouncer: the counter only runs while the synchronized input
        // disagrees with the accepted level; any agreeing sample restarts it.
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            db_cnt_d   = '0;
            db_level_d = sync2_q;
            press_rise = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        if (frame_tick) begin
            coll_latch_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (move_pending_q) begin
                        state_d = S_PLAY;
                        score_d = 8'd0;
                        consume = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (col) begin
                        state_d = S_DEAD;
                    end else if (move_pending_q) begin
                        state_d = S_SCROLL;
                        consume = 1'b1;
                    end
                end
                S_SCROLL: begin
                    if (col) begin
                        state_d  = S_DEAD;
                        scroll_d = 5'd0;
                    end else if (scroll_sum == LANE_EXT) begin
                        state_d    = S_PLAY;
                        scroll_d   = 5'd0;
                        lane_adv_d = 1'b1;
                        score_d    = sat_inc8(score_q);
                    end else begin
                        scroll_d = scroll_sum[4:0];
                    end
                end
                S_DEAD: begin
                    if (dead_cnt_q == DEAD_MAX) begin
                        state_d    = S_IDLE;
                        dead_cnt_d = 8'd0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A rise on the consuming tick re-arms the buffer for the next frame;
        // a rise while already pending is simply absorbed.
        move_pending_d = (move_pending_q & ~consume) | press_rise;
        if (state_q == S_DEAD) begin
            move_pending_d = 1'b0;
        end

        game_over_d = (state_d == S_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst_man) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_cnt_q       <= '0;
            db_level_q     <= 1'b0;
            move_pending_q <= 1'b0;
            coll_latch_q   <= 1'b0;
            dead_cnt_q     <= 8'd0;
            scroll_q       <= 5'd0;
            lane_adv_q     <= 1'b0;
            score_q        <= 8'd0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_cnt_q       <= db_cnt_d;
            db_level_q     <= db_level_d;
            move_pending_q <= move_pending_d;
            coll_latch_q   <= coll_latch_d;
            dead_cnt_q     <= dead_cnt_d;
            scroll_q       <= scroll_d;
            lane_adv_q     <= lane_adv_d;
            score_q        <= score_d;
            game_over_q    <= game_over_d;
        end
    end

    assign state         = state_q;
    assign scroll_offset = scroll_q;
    assign lane_advance  = lane_adv_q;
    assign score         = score_q;
    assign game_over     = game_over_q;

endmodule
